axis_pkt_sum: RTL and testbench

AXIS_PKT_SUM -- requirements
Module: axis_pkt_sum

---
 rtl/axis_pkt_sum_pkg.sv | 17 +
 rtl/axis_pkt_sum_sadd.sv | 36 +++
 rtl/axis_pkt_sum.sv | 116 +++++++++++
 tb/tb_axis_pkt_sum.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_sum_pkg.sv
// rtl/axis_pkt_sum_pkg.sv - shared FSM state type and signed saturation limits
package axis_pkt_sum_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  function automatic int sat_max(input int aw);
    return (1 <<< (aw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int aw);
    return -(1 <<< (aw - 1));
  endfunction

endpackage

// File: rtl/axis_pkt_sum_sadd.sv
// rtl/axis_pkt_sum_sadd.sv - signed add with overflow flag
// AXIS_PKT_SUM_SAT_EN selects saturation on overflow; otherwise two's complement wrap.
module axis_pkt_sum_sadd
  import axis_pkt_sum_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW:0] full;

`ifdef AXIS_PKT_SUM_SAT_EN
  localparam logic [AW-1:0] MAX_V = AW'(sat_max(AW));
  localparam logic [AW-1:0] MIN_V = AW'(sat_min(AW));
`endif

  always_comb begin
    full = {a[AW-1], a} + {b[AW-1], b};
    // Sign of the extended sum disagreeing with the AW-bit sign means the result left range.
    ovf  = full[AW] ^ full[AW-1];
`ifdef AXIS_PKT_SUM_SAT_EN
    if (ovf) begin
      sum = full[AW] ? MIN_V : MAX_V;
    end else begin
      sum = full[AW-1:0];
    end
`else
    sum = full[AW-1:0];
`endif
  end

endmodule

// File: rtl/axis_pkt_sum.sv
// rtl/axis_pkt_sum.sv - sums signed stream beats per packet and emits one result per packet
// Build option AXIS_PKT_SUM_SAT_EN: saturating accumulation (see axis_pkt_sum_sadd).
module axis_pkt_sum
  import axis_pkt_sum_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 10,
  parameter int MAX_LEN = 16,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [AW-1:0] m_tdata,
  output logic [CW-1:0] m_count,
  output logic          m_ovf,
  output logic          m_trunc
);

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] m_tdata_q, m_tdata_d;
  logic [CW-1:0] m_count_q, m_count_d;
  logic          m_ovf_q, m_ovf_d;
  logic          m_trunc_q, m_trunc_d;

  logic [AW-1:0] beat_ext;
  logic [AW-1:0] add_sum;
  logic          add_ovf;
  logic [CW-1:0] cnt_inc;
  logic          closing;

  assign beat_ext = {{(AW - DW){s_tdata[DW-1]}}, s_tdata};
  assign cnt_inc  = cnt_q + CW'(1);
  assign closing  = s_tlast || (cnt_inc == CW'(MAX_LEN));

  axis_pkt_sum_sadd #(.AW(AW)) u_sadd (
    .a   (acc_q),
    .b   (beat_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    m_tdata_d = m_tdata_q;
    m_count_d = m_count_q;
    m_ovf_d   = m_ovf_q;
    m_trunc_d = m_trunc_q;
    case (state_q)
      ACC: begin
        if (s_tvalid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (closing) begin
            m_tdata_d = add_sum;
            m_count_d = cnt_inc;
            m_ovf_d   = ovf_q | add_ovf;
            m_trunc_d = ~s_tlast;
            state_d   = OUT;
          end
        end
      end
      OUT: begin
        // Result registers keep their value after acceptance; only the accumulator restarts.
        if (m_tready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      m_tdata_q <= '0;
      m_count_q <= '0;
      m_ovf_q   <= 1'b0;
      m_trunc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      m_tdata_q <= m_tdata_d;
      m_count_q <= m_count_d;
      m_ovf_q   <= m_ovf_d;
      m_trunc_q <= m_trunc_d;
    end
  end

  assign s_tready = (state_q == ACC);
  assign m_tvalid = (state_q == OUT);
  assign m_tdata  = m_tdata_q;
  assign m_count  = m_count_q;
  assign m_ovf    = m_ovf_q;
  assign m_trunc  = m_trunc_q;

endmodule

// File: tb/tb_axis_pkt_sum.sv
// tb/tb_axis_pkt_sum.sv - self-checking bench for axis_pkt_sum with a packet-level reference model
module tb_axis_pkt_sum;

  localparam int DW      = 8;
  localparam int AW      = 10;
  localparam int MAX_LEN = 16;
  localparam int CW      = 5;
  localparam int HI      = (1 <<< (AW - 1)) - 1;
  localparam int LO      = -(1 <<< (AW - 1));
  localparam int NLIT    = 11;

`ifdef AXIS_PKT_SUM_SAT_EN
  localparam int POS_OVF_SUM = 511;
  localparam int NEG_OVF_SUM = -512;
`else
  localparam int POS_OVF_SUM = -389;
  localparam int NEG_OVF_SUM = 384;
`endif

  logic                 clk = 1'b0;
  logic                 areset = 1'b1;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready;
  logic signed [DW-1:0] s_tdata = '0;
  logic                 s_tlast = 1'b0;
  logic                 m_tvalid;
  logic                 m_tready = 1'b1;
  logic signed [AW-1:0] m_tdata;
  logic [CW-1:0]        m_count;
  logic                 m_ovf;
  logic                 m_trunc;

  always #5 clk = ~clk;

  axis_pkt_sum #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN), .CW(CW)) dut (
    .ACLK     (clk),
    .ARESET   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_count  (m_count),
    .m_ovf    (m_ovf),
    .m_trunc  (m_trunc)
  );

  typedef struct {
    int sum;
    int cnt;
    int ovf;
    int trunc;
    int close_cyc;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t log_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   dut_outs = 0;
  bit   mon_en = 1'b0;
  bit   prev_mv = 1'b0;
  int   mdl_acc = 0;
  int   mdl_cnt = 0;
  int   mdl_ovf = 0;

  int lit_sum   [NLIT] = '{8, -128, POS_OVF_SUM, 16, 1, 32, NEG_OVF_SUM, -10, 150, 8, 9};
  int lit_cnt   [NLIT] = '{3, 1, 5, 16, 1, 16, 5, 2, 2, 2, 1};
  int lit_ovf   [NLIT] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
  int lit_trunc [NLIT] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: integer running sum, range check, then clamp or wrap.
  task automatic model_beat(input int x, input bit last);
    int   t;
    pkt_t p;
    t = mdl_acc + x;
    if (t > HI || t < LO) begin
      mdl_ovf = 1;
`ifdef AXIS_PKT_SUM_SAT_EN
      t = (t > HI) ? HI : LO;
`else
      t = (t > HI) ? t - (1 <<< AW) : t + (1 <<< AW);
`endif
    end
    mdl_acc = t;
    mdl_cnt++;
    if (last || mdl_cnt == MAX_LEN) begin
      p.sum       = mdl_acc;
      p.cnt       = mdl_cnt;
      p.ovf       = mdl_ovf;
      p.trunc     = (!last) ? 1 : 0;
      p.close_cyc = cyc;
      exp_q.push_back(p);
      log_q.push_back(p);
      mdl_acc = 0;
      mdl_cnt = 0;
      mdl_ovf = 0;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (m_tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("m_tvalid_unexpected", m_tvalid, 0);
        end else begin
          chk("m_tdata", m_tdata, exp_q[0].sum);
          chk("m_count", m_count, exp_q[0].cnt);
          chk("m_ovf", m_ovf, exp_q[0].ovf);
          chk("m_trunc", m_trunc, exp_q[0].trunc);
          if (!prev_mv) chk("latency", cyc, exp_q[0].close_cyc + 1);
        end
      end
      chk("s_tready_vs_m_tvalid", s_tready, !m_tvalid);
      if (areset) begin
        exp_q.delete();
        mdl_acc = 0;
        mdl_cnt = 0;
        mdl_ovf = 0;
      end else begin
        if (m_tvalid && m_tready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          dut_outs++;
        end
        if (s_tvalid && s_tready) model_beat(int'(s_tdata), s_tlast);
      end
      prev_mv = m_tvalid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input bit last);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = DW'(x);
    s_tlast  = last;
    do begin
      @(negedge clk);
      n++;
    end while (s_tready !== 1'b1 && n < 50);
    if (s_tready !== 1'b1) chk("send_timeout", s_tready, 1);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_tvalid !== 1'b1 && n < 50);
    chk("wait_m_tvalid", m_tvalid, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_m_ovf", m_ovf, 0);
    chk("rst_m_trunc", m_trunc, 0);
    step();

    send(3, 0); send(-5, 0); send(10, 1); drain();
    send(-128, 1); drain();
    for (int i = 1; i <= 5; i++) send(127, i == 5);
    drain();
    for (int i = 1; i <= 17; i++) send(1, i == 17);
    drain();
    for (int i = 1; i <= 16; i++) send(2, i == 16);
    drain();
    for (int i = 1; i <= 5; i++) send(-128, i == 5);
    drain();

    // Backpressure: result held for several cycles with input stalled.
    m_tready = 1'b0;
    send(20, 0); send(-30, 1);
    wait_mvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_s_tready", s_tready, 0);
      chk("hold_m_tdata", m_tdata, -10);
    end
    step();
    m_tready = 1'b1;
    send(100, 0); send(50, 1); drain();

    // Reset mid-packet discards the partial sum.
    send(7, 0); send(7, 0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", s_tready, 1);
    chk("post_rst_m_tvalid", m_tvalid, 0);
    step();
    send(4, 0); send(4, 1); drain();

    // Reset while a result is held drops it without a handshake.
    m_tready = 1'b0;
    send(9, 1);
    wait_mvalid();
    step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("rst_out_m_tvalid", m_tvalid, 0);
    chk("rst_out_m_tdata", m_tdata, 0);
    repeat (3) @(negedge clk);
    step();

    chk("model_pkt_count", log_q.size(), NLIT);
    chk("dut_pkt_count", dut_outs, NLIT - 1);
    for (int i = 0; i < NLIT && i < log_q.size(); i++) begin
      chk($sformatf("lit_sum[%0d]", i), log_q[i].sum, lit_sum[i]);
      chk($sformatf("lit_cnt[%0d]", i), log_q[i].cnt, lit_cnt[i]);
      chk($sformatf("lit_ovf[%0d]", i), log_q[i].ovf, lit_ovf[i]);
      chk($sformatf("lit_trunc[%0d]", i), log_q[i].trunc, lit_trunc[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
